// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding, default timing and helper for the key reader
package key_pkg;
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT} key_fsm_e;
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int LONG_DEFAULT = 50000000;
  localparam int NUM_KEYS = 4;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-key synchronizer, debounce/hold FSM and registered event strobes
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES = LONG_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_flag
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
  logic [1:0] sync;
  logic s;
  key_fsm_e state;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  assign s = sync[1];
  // Two-flop synchronizer; resets to the released level so reset never looks like a press
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) sync <= 2'b11;
    else sync <= {sync[0], key};
  // Debounce/hold FSM; the IDLE->PRESS_WAIT and HELD->RELEASE_WAIT edges count as the first stable sample, a saturated hold count marks a long hold
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      dcnt <= '0;
      hcnt <= '0;
      key_state <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
      long_flag <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
      case (state)
        IDLE:
          if (!s) begin
            state <= PRESS_WAIT;
            dcnt <= '0;
          end
        PRESS_WAIT:
          if (s) state <= IDLE;
          else if (dcnt == D_LAST) begin
            state <= HELD;
            hcnt <= '0;
            press_pulse <= 1'b1;
            key_state <= 1'b1;
          end else dcnt <= dcnt + 1'b1;
        HELD:
          if (s) begin
            state <= RELEASE_WAIT;
            dcnt <= '0;
          end else if (hcnt == H_LAST) begin
            state <= LONG_HELD;
            hcnt <= H_MAX;
            long_pulse <= 1'b1;
            long_flag <= 1'b1;
          end else hcnt <= hcnt + 1'b1;
        LONG_HELD:
          if (s) begin
            state <= RELEASE_WAIT;
            dcnt <= '0;
          end
        RELEASE_WAIT:
          if (!s) begin
            if (hcnt == H_MAX) state <= LONG_HELD;
            else if (hcnt == H_LAST) begin
              state <= LONG_HELD;
              hcnt <= H_MAX;
              long_pulse <= 1'b1;
              long_flag <= 1'b1;
            end else begin
              state <= HELD;
              hcnt <= hcnt + 1'b1;
            end
          end else if (dcnt == D_LAST) begin
            state <= IDLE;
            release_pulse <= 1'b1;
            key_state <= 1'b0;
            long_flag <= 1'b0;
          end else dcnt <= dcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/key_reader.sv
// key_reader: four debounced pushbuttons with press counter and LED mapping
module key_reader
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES = LONG_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  output logic [3:0] key_state,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic [3:0] long_pulse,
  output logic [7:0] LEDG,
  output logic [9:0] LEDR
);
  logic [3:0] long_flag;
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_key (
      .CLOCK_50(CLOCK_50),
      .RESET_N(RESET_N),
      .key(KEY[g]),
      .key_state(key_state[g]),
      .press_pulse(press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse(long_pulse[g]),
      .long_flag(long_flag[g])
    );
  end
  assign LEDG = {long_flag, key_state};
  // Accepted-press counter, wraps modulo 1024; simultaneous presses all count
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) LEDR <= '0;
    else LEDR <= LEDR + 10'(popcount4(press_pulse));
endmodule

// File: tb/tb_key_reader.sv
// tb_key_reader: directed and randomized checks of key_reader against a run-length reference model
module tb_key_reader;
  localparam int D = 4;
  localparam int L = 16;
  logic CLOCK_50 = 1'b0;
  logic RESET_N;
  logic [3:0] KEY;
  logic [3:0] key_state, press_pulse, release_pulse, long_pulse;
  logic [7:0] LEDG;
  logic [9:0] LEDR;
  int total = 0;
  int bad = 0;

  key_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .KEY(KEY),
    .key_state(key_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .LEDG(LEDG),
    .LEDR(LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: a key is accepted as pressed/released when the synchronized level has been stable for D samples;
  // the hold count is the number of low samples seen while pressed, and a long press fires when it reaches L.
  logic [3:0] q1, q2, e_press, e_rel, e_long, e_state, e_lflag;
  logic [9:0] e_cnt;
  int run[4];
  bit lvl[4];
  int hold[4];
  logic [33:0] dut_v, exp_v;
  assign dut_v = {key_state, press_pulse, release_pulse, long_pulse, LEDG, LEDR};
  assign exp_v = {e_state, e_press, e_rel, e_long, e_lflag, e_state, e_cnt};

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      q1 = '1; q2 = '1; e_cnt = '0;
      e_press = '0; e_rel = '0; e_long = '0; e_state = '0; e_lflag = '0;
      for (int k = 0; k < 4; k++) begin lvl[k] = 1'b1; run[k] = 0; hold[k] = 0; end
    end else begin
      e_cnt = e_cnt + 10'($countones(e_press));
      for (int k = 0; k < 4; k++) begin
        if (q2[k] == lvl[k]) run[k]++;
        else begin lvl[k] = q2[k]; run[k] = 1; end
        e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0;
        if (!e_state[k] && !lvl[k] && run[k] == D) begin e_state[k] = 1'b1; hold[k] = 0; e_press[k] = 1'b1; end
        else if (e_state[k] && lvl[k] && run[k] == D) begin e_state[k] = 1'b0; e_rel[k] = 1'b1; end
        else if (e_state[k] && !lvl[k] && hold[k] < L) begin hold[k]++; e_long[k] = (hold[k] == L); end
        e_lflag[k] = e_state[k] && hold[k] == L;
      end
      q2 = q1; q1 = KEY;
    end
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; KEY = '1;
    #3;
    total++; if (dut_v !== '0) begin bad++; $display("FAIL reset_async: got %h want 0", dut_v); end
    repeat (3) tick;
    total++; if (dut_v !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", dut_v); end
    RESET_N = 1'b1;
    repeat (5) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL reset_idle: got %h want %h", dut_v, exp_v); end
    end
  endtask

  task automatic test_clean_press;
    int hit = 0;
    KEY[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL clean_model: got %h want %h", dut_v, exp_v); end
      if (press_pulse[0]) hit += (i == 6) ? 1 : 100;
    end
    total++; if (hit !== 1) begin bad++; $display("FAIL clean_latency: got code %0d want 1", hit); end
    total++; if ({key_state[0], LEDR} !== {1'b1, 10'd1}) begin bad++; $display("FAIL clean_state: got %b/%0d want 1/1", key_state[0], LEDR); end
    KEY[0] = 1'b1;
    repeat (10) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL clean_release: got %h want %h", dut_v, exp_v); end
    end
  endtask

  task automatic test_bounce;
    int n = 0, at = 0;
    KEY[1] = 1'b0;
    repeat (3) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL bounce_low: got %h want %h", dut_v, exp_v); end
    end
    KEY[1] = 1'b1;
    tick;
    total++; if (dut_v !== exp_v) begin bad++; $display("FAIL bounce_high: got %h want %h", dut_v, exp_v); end
    KEY[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL bounce_model: got %h want %h", dut_v, exp_v); end
      if (press_pulse[1]) begin n++; at = i; end
    end
    total++; if (n !== 1 || at !== 6) begin bad++; $display("FAIL bounce_pulse: got count %0d at %0d want 1 at 6", n, at); end
    KEY[1] = 1'b1;
    repeat (10) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL bounce_release: got %h want %h", dut_v, exp_v); end
    end
  endtask

  task automatic test_long_press;
    int np = 0, nl = 0, nr = 0, pp = 0, lp = 0;
    logic led = 1'b0;
    KEY[2] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL long_model: got %h want %h", dut_v, exp_v); end
      if (nl == 1 && i == lp + 1) led = LEDG[6];
      if (press_pulse[2]) begin np++; pp = i; end
      if (long_pulse[2]) begin nl++; lp = i; end
      if (release_pulse[2]) nr++;
      if (i == 30) KEY[2] = 1'b1;
    end
    total++; if (np !== 1 || nl !== 1 || lp - pp !== L) begin bad++; $display("FAIL long_pulse: got press %0d long %0d gap %0d want 1 1 %0d", np, nl, lp - pp, L); end
    total++; if (led !== 1'b1) begin bad++; $display("FAIL long_led_on: got %b want 1", led); end
    total++; if (nr !== 1 || LEDG[6] !== 1'b0) begin bad++; $display("FAIL long_release: got count %0d led %b want 1 0", nr, LEDG[6]); end
  endtask

  task automatic test_simultaneous;
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    for (int r = 0; r < 256; r++) begin
      KEY = (r == 255) ? 4'b1100 : 4'b0000;
      repeat (8) begin
        tick;
        total++; if (dut_v !== exp_v) begin bad++; $display("FAIL preset_press: got %h want %h", dut_v, exp_v); end
      end
      KEY = '1;
      repeat (8) begin
        tick;
        total++; if (dut_v !== exp_v) begin bad++; $display("FAIL preset_release: got %h want %h", dut_v, exp_v); end
      end
    end
    total++; if (LEDR !== 10'd1022) begin bad++; $display("FAIL preset_count: got %0d want 1022", LEDR); end
    KEY = '0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL simul_model: got %h want %h", dut_v, exp_v); end
      if (i == 6) begin
        total++; if (press_pulse !== 4'hf) begin bad++; $display("FAIL simul_pulse: got %b want 1111", press_pulse); end
      end
    end
    total++; if (LEDR !== 10'd2) begin bad++; $display("FAIL simul_wrap: got %0d want 2", LEDR); end
    KEY = '1;
    repeat (10) tick;
  endtask

  task automatic test_reset_mid;
    int n = 0, at = 0;
    KEY[0] = 1'b0;
    repeat (4) tick;
    #2 RESET_N = 1'b0;
    #1;
    total++; if (dut_v !== '0) begin bad++; $display("FAIL mid_reset_wait: got %h want 0", dut_v); end
    repeat (2) tick;
    RESET_N = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL mid_redebounce: got %h want %h", dut_v, exp_v); end
      if (press_pulse[0]) begin n++; at = i; end
    end
    total++; if (n !== 1 || at !== 6) begin bad++; $display("FAIL mid_latency: got count %0d at %0d want 1 at 6", n, at); end
    KEY[3] = 1'b0;
    repeat (26) begin
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL mid_long_model: got %h want %h", dut_v, exp_v); end
    end
    total++; if (LEDG[7] !== 1'b1) begin bad++; $display("FAIL mid_long_flag: got %b want 1", LEDG[7]); end
    #2 RESET_N = 1'b0;
    #1;
    total++; if (dut_v !== '0) begin bad++; $display("FAIL mid_reset_long: got %h want 0", dut_v); end
    KEY = '1;
    repeat (2) tick;
    RESET_N = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick;
      total++; if ({press_pulse, release_pulse, long_pulse} !== '0 || dut_v !== exp_v) begin bad++; $display("FAIL mid_no_pulse: got %h want %h", dut_v, exp_v); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3 + 12 * k) == 0) KEY[k] = ~KEY[k];
      if (i == 750) begin
        #2 RESET_N = 1'b0;
        #1;
        total++; if (dut_v !== '0) begin bad++; $display("FAIL random_reset: got %h want 0", dut_v); end
        tick;
        RESET_N = 1'b1;
      end
      tick;
      total++; if (dut_v !== exp_v) begin bad++; $display("FAIL random_model: got %h want %h", dut_v, exp_v); end
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_long_press;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
